// File: rtl/dm_pkg.sv
// Shared definitions for the dm_resp data-memory responder: access-type encodings,
// default depth, and helpers for access size, byte lanes and alignment.
package dm_pkg;

  localparam int DEPTH_WORDS_DEF = 1024;

  typedef enum logic [2:0] {
    DM_WORD   = 3'b000,
    DM_HALF   = 3'b001,
    DM_HALF_U = 3'b010,
    DM_BYTE   = 3'b011,
    DM_BYTE_U = 3'b100
  } dm_type_e;

  typedef enum logic [1:0] {
    SZ_WORD,
    SZ_HALF,
    SZ_BYTE
  } dm_size_e;

  // Encodings 101-111 behave as word accesses.
  function automatic dm_size_e size_of(logic [2:0] t);
    case (t)
      DM_HALF, DM_HALF_U: size_of = SZ_HALF;
      DM_BYTE, DM_BYTE_U: size_of = SZ_BYTE;
      default:            size_of = SZ_WORD;
    endcase
  endfunction

  function automatic logic is_signed(logic [2:0] t);
    is_signed = (t == DM_HALF) || (t == DM_BYTE);
  endfunction

  // Byte offset actually used: words ignore [1:0], halves ignore [0].
  function automatic logic [1:0] eff_off(dm_size_e s, logic [1:0] a);
    case (s)
      SZ_HALF: eff_off = {a[1], 1'b0};
      SZ_BYTE: eff_off = a;
      default: eff_off = 2'b00;
    endcase
  endfunction

  function automatic logic [3:0] byte_en(dm_size_e s, logic [1:0] off);
    case (s)
      SZ_HALF: byte_en = off[1] ? 4'b1100 : 4'b0011;
      SZ_BYTE: byte_en = 4'b0001 << off;
      default: byte_en = 4'b1111;
    endcase
  endfunction

  function automatic logic is_misaligned(dm_size_e s, logic [1:0] a);
    is_misaligned = ((s == SZ_WORD) && (a != 2'b00)) || ((s == SZ_HALF) && a[0]);
  endfunction

endpackage

// File: rtl/dm_resp_if.sv
// CPU data-port bundle between a requester (master) and dm_resp (slave).
// Handshake: mem_r/mem_w are single-cycle request strobes with no ready; every request
// is accepted in the cycle it is presented, loads answer combinationally on Data_out.
interface dm_resp_if;
  logic        mem_r;
  logic        mem_w;
  logic [31:0] Addr_in;
  logic [31:0] Data_in;
  logic [2:0]  DMType;
  logic [31:0] Data_out;
  logic        wr_pending;
  logic        misalign_err;

  modport master (
    output mem_r, mem_w, Addr_in, Data_in, DMType,
    input  Data_out, wr_pending, misalign_err
  );

  modport slave (
    input  mem_r, mem_w, Addr_in, Data_in, DMType,
    output Data_out, wr_pending, misalign_err
  );
endinterface

// File: rtl/dm_load_ext.sv
// Load lane selection and sign/zero extension for one 32-bit word.
module dm_load_ext
  import dm_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  off,
  input  logic [2:0]  dm_type,
  output logic [31:0] data
);

  dm_size_e    sz;
  logic        sgn;
  logic [15:0] half_v;
  logic [7:0]  byte_v;

  assign sz     = size_of(dm_type);
  assign sgn    = is_signed(dm_type);
  assign half_v = off[1] ? word[31:16] : word[15:0];
  assign byte_v = word[{off, 3'b000} +: 8];

  always_comb begin
    data = word;
    case (sz)
      SZ_HALF: data = {{16{sgn & half_v[15]}}, half_v};
      SZ_BYTE: data = {{24{sgn & byte_v[7]}}, byte_v};
      default: data = word;
    endcase
  end

endmodule

// File: rtl/dm_resp.sv
// Data memory with a one-entry write buffer and load forwarding.
// Define DM_MISALIGN_TRAP_EN to reject misaligned accesses and raise sticky misalign_err.
module dm_resp
  import dm_pkg::*;
#(
  parameter int DEPTH_WORDS = DEPTH_WORDS_DEF
) (
  input  logic       clk,
  input  logic       rst,
  dm_resp_if.slave   bus
);

  localparam int AW = $clog2(DEPTH_WORDS);

  dm_size_e    sz;
  logic [1:0]  off;
  logic [3:0]  be;
  logic [AW-1:0] idx;
  logic        mis;
  logic        store_ok;
  logic [31:0] lane_data;

  logic          wb_valid;
  logic [AW-1:0] wb_idx;
  logic [3:0]    wb_be;
  logic [31:0]   wb_data;

  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] arr_word;
  logic [31:0] fwd_word;
  logic [31:0] ext_word;
  logic        unused_addr;

  assign sz          = size_of(bus.DMType);
  assign off         = eff_off(sz, bus.Addr_in[1:0]);
  assign be          = byte_en(sz, off);
  assign idx         = bus.Addr_in[AW+1:2];
  assign unused_addr = ^bus.Addr_in[31:AW+2];

`ifdef DM_MISALIGN_TRAP_EN
  logic err_q;

  assign mis = is_misaligned(sz, bus.Addr_in[1:0]);

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if ((bus.mem_r || bus.mem_w) && mis) begin
      err_q <= 1'b1;
    end
  end

  assign bus.misalign_err = err_q;
`else
  assign mis              = 1'b0;
  assign bus.misalign_err = 1'b0;
`endif

  assign store_ok = bus.mem_w && !mis;

  // Replicating the payload across lanes lets byte enables alone pick the target lane.
  always_comb begin
    lane_data = bus.Data_in;
    case (sz)
      SZ_HALF: lane_data = {2{bus.Data_in[15:0]}};
      SZ_BYTE: lane_data = {4{bus.Data_in[7:0]}};
      default: lane_data = bus.Data_in;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_valid <= 1'b0;
    end else begin
      wb_valid <= store_ok;
      if (store_ok) begin
        wb_idx  <= idx;
        wb_be   <= be;
        wb_data <= lane_data;
      end
    end
  end

  // Drain is unconditional one edge after capture; reset discards instead of draining.
  always_ff @(posedge clk) begin
    if (!rst && wb_valid) begin
      for (int i = 0; i < 4; i++) begin
        if (wb_be[i]) mem[wb_idx][8*i +: 8] <= wb_data[8*i +: 8];
      end
    end
  end

  assign arr_word = mem[idx];

  always_comb begin
    fwd_word = arr_word;
    for (int i = 0; i < 4; i++) begin
      if (wb_valid && (wb_idx == idx) && wb_be[i]) fwd_word[8*i +: 8] = wb_data[8*i +: 8];
    end
  end

  dm_load_ext u_ext (
    .word    (fwd_word),
    .off     (off),
    .dm_type (bus.DMType),
    .data    (ext_word)
  );

  assign bus.Data_out   = (bus.mem_r && !mis) ? ext_word : 32'h0;
  assign bus.wr_pending = wb_valid;

endmodule

// File: tb/tb_dm_resp.sv
// Self-checking bench for dm_resp: byte-level memory model with a pending-store queue,
// directed literal checks and randomized traffic.
module tb_dm_resp;

  localparam int          DEPTH = 1024;
  localparam logic [31:0] AMASK = 32'(DEPTH * 4 - 1);

  typedef struct {
    logic [31:0] addr;
    int          nb;
    logic [31:0] data;
  } st_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dm_resp_if bus ();

  dm_resp #(.DEPTH_WORDS(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [7:0] mbyte [int];
  st_t        pend_q [$];
  bit         m_err    = 1'b0;
  bit         checking = 1'b0;
  int         n_cmp    = 0;
  int         n_bad    = 0;

  function automatic int nbytes(logic [2:0] t);
    if (t == 3'd1 || t == 3'd2) return 2;
    if (t == 3'd3 || t == 3'd4) return 1;
    return 4;
  endfunction

  function automatic bit tb_mis(logic [2:0] t, logic [31:0] a);
`ifdef DM_MISALIGN_TRAP_EN
    return (nbytes(t) == 4 && a[1:0] != 2'b00) || (nbytes(t) == 2 && a[0]);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] base(logic [2:0] t, logic [31:0] a);
    return (a & AMASK) & ~32'(nbytes(t) - 1);
  endfunction

  // Byte as a load sees it: committed memory overlaid by not-yet-committed stores.
  function automatic logic [7:0] peek(int ba);
    logic [7:0] b;
    b = mbyte.exists(ba) ? mbyte[ba] : 8'h00;
    foreach (pend_q[k]) begin
      if (ba >= int'(pend_q[k].addr) && ba < int'(pend_q[k].addr) + pend_q[k].nb)
        b = pend_q[k].data[8*(ba - int'(pend_q[k].addr)) +: 8];
    end
    return b;
  endfunction

  function automatic logic [31:0] exp_load(logic r, logic [2:0] t, logic [31:0] a);
    logic [31:0] v;
    int          b;
    if (!r || tb_mis(t, a)) return 32'h0;
    b = int'(base(t, a));
    v = 32'h0;
    for (int i = 0; i < nbytes(t); i++) v = v | (32'(peek(b + i)) << (8 * i));
    if (t == 3'd1 && v[15]) v = v | 32'hFFFF0000;
    if (t == 3'd3 && v[7])  v = v | 32'hFFFFFF00;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h at %0t", nm, act, exp_v, $time);
    end
  endtask

  always @(posedge clk) begin
    st_t p;
    if (rst) begin
      pend_q.delete();
      m_err = 1'b0;
    end else begin
      while (pend_q.size() > 0) begin
        p = pend_q.pop_front();
        for (int i = 0; i < p.nb; i++) mbyte[int'(p.addr) + i] = p.data[8*i +: 8];
      end
      if (bus.mem_w && !tb_mis(bus.DMType, bus.Addr_in))
        pend_q.push_back('{base(bus.DMType, bus.Addr_in), nbytes(bus.DMType), bus.Data_in});
      if ((bus.mem_r || bus.mem_w) && tb_mis(bus.DMType, bus.Addr_in)) m_err = 1'b1;
    end
  end

  always @(negedge clk) begin
    #2;
    if (checking) begin
      chk("data_out", bus.Data_out, exp_load(bus.mem_r, bus.DMType, bus.Addr_in));
      chk("wr_pending", {31'b0, bus.wr_pending}, {31'b0, pend_q.size() != 0});
      chk("misalign_err", {31'b0, bus.misalign_err}, {31'b0, m_err});
    end
  end

  task automatic drive(input bit r, input bit w, input logic [2:0] t,
                       input logic [31:0] a, input logic [31:0] d, input bit rs = 1'b0);
    @(negedge clk);
    bus.mem_r   = r;
    bus.mem_w   = w;
    bus.DMType  = t;
    bus.Addr_in = a;
    bus.Data_in = d;
    rst         = rs;
  endtask

  task automatic lit(input string nm, input logic [31:0] exp_v);
    #3;
    chk(nm, bus.Data_out, exp_v);
    chk({nm, "_model"}, exp_load(bus.mem_r, bus.DMType, bus.Addr_in), exp_v);
  endtask

  initial begin
    bus.mem_r = 1'b0; bus.mem_w = 1'b0; bus.DMType = 3'd0;
    bus.Addr_in = 32'h0; bus.Data_in = 32'h0;
    repeat (2) @(posedge clk);
    #1 checking = 1'b1;

    drive(1'b0, 1'b1, 3'd0, 32'h10, 32'hFFFF_FFFF, 1'b1);
    lit("reset_data", 32'h0);
    chk("reset_wp", {31'b0, bus.wr_pending}, 32'h0);
    chk("reset_err", {31'b0, bus.misalign_err}, 32'h0);

    for (int i = 0; i < 32; i++) drive(1'b0, 1'b1, 3'd0, 32'(i * 4), 32'h0);
    drive(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);

    drive(1'b0, 1'b1, 3'd0, 32'h10, 32'h12345678);
    drive(1'b1, 1'b0, 3'd0, 32'h10, 32'h0);
    lit("sw_fwd", 32'h12345678);
    chk("sw_fwd_wp", {31'b0, bus.wr_pending}, 32'h1);
    drive(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 3'd0, 32'h10, 32'h0);
    lit("sw_arr", 32'h12345678);
    chk("sw_arr_wp", {31'b0, bus.wr_pending}, 32'h0);

    drive(1'b0, 1'b1, 3'd3, 32'h11, 32'h000000AB);
    drive(1'b1, 1'b0, 3'd0, 32'h10, 32'h0); lit("sb_lw", 32'h1234AB78);
    drive(1'b1, 1'b0, 3'd3, 32'h11, 32'h0); lit("sb_lb", 32'hFFFFFFAB);
    drive(1'b1, 1'b0, 3'd4, 32'h11, 32'h0); lit("sb_lbu", 32'h000000AB);

    drive(1'b0, 1'b1, 3'd1, 32'h22, 32'h00008001);
    drive(1'b1, 1'b0, 3'd1, 32'h22, 32'h0); lit("sh_lh", 32'hFFFF8001);
    drive(1'b1, 1'b0, 3'd2, 32'h22, 32'h0); lit("sh_lhu", 32'h00008001);
    drive(1'b1, 1'b0, 3'd0, 32'h20, 32'h0); lit("sh_lw", 32'h80010000);

    drive(1'b0, 1'b1, 3'd0, 32'h0, 32'h1);
    drive(1'b0, 1'b1, 3'd0, 32'h4, 32'h2);
    drive(1'b0, 1'b1, 3'd0, 32'h0, 32'h3);
    drive(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 3'd0, 32'h0, 32'h0); lit("b2b_0", 32'h3);
    drive(1'b1, 1'b0, 3'd0, 32'h4, 32'h0); lit("b2b_4", 32'h2);
    drive(1'b1, 1'b1, 3'd0, 32'h0, 32'h55); lit("rw_old", 32'h3);
    drive(1'b1, 1'b0, 3'd0, 32'h0, 32'h0); lit("rw_new", 32'h55);

    drive(1'b0, 1'b1, 3'd0, 32'h8, 32'hDEADBEEF, 1'b1);
    drive(1'b1, 1'b0, 3'd0, 32'h8, 32'h0); lit("rst_sw", 32'h0);
    chk("rst_sw_wp", {31'b0, bus.wr_pending}, 32'h0);
    drive(1'b0, 1'b1, 3'd0, 32'h8, 32'hCAFE0000);
    drive(1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 1'b1);
    drive(1'b1, 1'b0, 3'd0, 32'h8, 32'h0); lit("rst_drop", 32'h0);

    drive(1'b1, 1'b0, 3'd0, 32'h6, 32'h0);
`ifdef DM_MISALIGN_TRAP_EN
    lit("mis_lw", 32'h0);
    drive(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
    #3 chk("mis_err_set", {31'b0, bus.misalign_err}, 32'h1);
    drive(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
    #3 chk("mis_err_hold", {31'b0, bus.misalign_err}, 32'h1);
    drive(1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 1'b1);
    drive(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
    #3 chk("mis_err_clr", {31'b0, bus.misalign_err}, 32'h0);
`else
    lit("mis_lw", 32'h2);
    drive(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
    #3 chk("mis_err_tied", {31'b0, bus.misalign_err}, 32'h0);
`endif

    for (int n = 0; n < 600; n++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
            $urandom & 32'hFFFFF07F, $urandom, $urandom_range(0, 39) == 0);
    end
    drive(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
    drive(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
    @(negedge clk);
    #4;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
